// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory block.
package data_mem_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_PEND = 1'b1
  } dm_state_t;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/data_ram_core.sv
// Single-port word array with per-byte write enables and parametrised power-up
// contents; the array itself has no reset and no control logic.
module ram_core
  import data_mem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 16,
  parameter int INIT_WORDS = 4
) (
  input  logic                          clk,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          we,
  input  logic [be_width(DATA_W)-1:0]   be,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata
);

  localparam int BE_W = be_width(DATA_W);

  logic [DATA_W-1:0] words [DEPTH];

  // One register per word so each can carry its own power-up value.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [DATA_W-1:0] word = DATA_W'((i < INIT_WORDS) ? i + 1 : 0);

    always_ff @(posedge clk) begin
      if (we && (addr == ADDR_W'(i))) begin
        for (int unsigned k = 0; k < BE_W; k++) begin
          if (be[k]) word[8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end

    assign words[i] = word;
  end

  always_comb begin
    rdata = '0;
    if (32'(addr) < DEPTH) rdata = words[addr];
  end

endmodule

// File: rtl/data_ram.sv
// Data memory front end: request arbitration, write-then-read serialisation
// through RD_PEND, address range check and registered outputs.
module data_ram
  import data_mem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 16,
  parameter int INIT_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic                          wr_req,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [be_width(DATA_W)-1:0]   wr_be,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic                          wr_done,
  output logic                          busy,
  output logic                          err_addr
);

  if (DATA_W % 8 != 0) begin : g_chk_w
    $error("data_ram: DATA_W must be a multiple of 8");
  end
  if (DEPTH > 2**ADDR_W) begin : g_chk_d
    $error("data_ram: DEPTH exceeds address space");
  end

  dm_state_t         state, state_next;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] core_addr;
  logic              core_we;
  logic [DATA_W-1:0] core_rdata;
  logic              rd_ok, wr_ok, pend_ok;

  assign rd_ok   = 32'(rd_addr)   < DEPTH;
  assign wr_ok   = 32'(wr_addr)   < DEPTH;
  assign pend_ok = 32'(pend_addr) < DEPTH;

  ram_core #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .INIT_WORDS (INIT_WORDS)
  ) u_core (
    .clk   (clk),
    .addr  (core_addr),
    .we    (core_we),
    .be    (wr_be),
    .wdata (wr_data),
    .rdata (core_rdata)
  );

  // The single array port goes to the write when both requests collide; the
  // read is replayed from pend_addr next cycle and so sees post-write data.
  always_comb begin
    state_next = state;
    core_addr  = rd_addr;
    core_we    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          core_addr = wr_addr;
          core_we   = wr_ok;
          if (rd_req) state_next = RD_PEND;
        end
      end
      RD_PEND: begin
        core_addr  = pend_addr;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend_addr <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      wr_done   <= 1'b0;
      busy      <= 1'b0;
      err_addr  <= 1'b0;
    end else begin
      state    <= state_next;
      busy     <= (state_next == RD_PEND);
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      err_addr <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            wr_done  <= 1'b1;
            err_addr <= !wr_ok;
            if (rd_req) pend_addr <= rd_addr;
          end else if (rd_req) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_ok ? core_rdata : '0;
            err_addr <= !rd_ok;
          end
        end
        RD_PEND: begin
          rd_valid <= 1'b1;
          rd_data  <= pend_ok ? core_rdata : '0;
          err_addr <= !pend_ok;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram built with DEPTH=12 so out-of-range addresses
// exist inside the 4-bit address space.
module tb_data_ram;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rd_req, wr_req;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_be;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, wr_done, busy, err_addr;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  data_ram #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .INIT_WORDS (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_done  (wr_done),
    .busy     (busy),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0;  wr_addr = '0;
    wr_data = '0;  wr_be = 2'b00;
  endtask

  logic [DATA_W-1:0] exp_mem [16];

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    check("rst rd_data", 32'(rd_data), 0);
    check("rst rd_valid", 32'(rd_valid), 0);
    check("rst wr_done", 32'(wr_done), 0);
    check("rst busy", 32'(busy), 0);
    check("rst err_addr", 32'(err_addr), 0);
    rst_n = 1'b1;

    // Power-up contents, reads issued back to back.
    exp_mem = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0,
                16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    for (int a = 0; a < 6; a++) begin
      rd_req = 1'b1; rd_addr = ADDR_W'(a);
      tick();
      check($sformatf("init valid %0d", a), 32'(rd_valid), 1);
      check($sformatf("init data %0d", a), 32'(rd_data), 32'(exp_mem[a]));
      check($sformatf("init err %0d", a), 32'(err_addr), 0);
    end
    idle_inputs();
    tick();
    check("valid drops", 32'(rd_valid), 0);

    // Low byte only.
    wr_req = 1'b1; wr_addr = 4'd7; wr_data = 16'hABCD; wr_be = 2'b01;
    tick();
    idle_inputs();
    check("be01 wr_done", 32'(wr_done), 1);
    check("be01 err", 32'(err_addr), 0);
    check("be01 busy", 32'(busy), 0);
    exp_mem[7] = 16'h00CD;
    rd_req = 1'b1; rd_addr = 4'd7;
    tick();
    idle_inputs();
    check("be01 readback", 32'(rd_data), 32'h00CD);

    // Zero byte enables: done pulses, nothing written.
    wr_req = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; wr_be = 2'b00;
    tick();
    idle_inputs();
    check("be00 wr_done", 32'(wr_done), 1);
    rd_req = 1'b1; rd_addr = 4'd0;
    tick();
    idle_inputs();
    check("be00 readback", 32'(rd_data), 32'h0001);

    // Collision: write wins the port, read follows with post-write data.
    wr_req = 1'b1; wr_addr = 4'd2; wr_data = 16'h1234; wr_be = 2'b11;
    rd_req = 1'b1; rd_addr = 4'd2;
    tick();
    exp_mem[2] = 16'h1234;
    check("coll wr_done", 32'(wr_done), 1);
    check("coll busy", 32'(busy), 1);
    check("coll no early valid", 32'(rd_valid), 0);
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 4'd5;
    tick();
    check("coll rd_valid", 32'(rd_valid), 1);
    check("coll rd_data", 32'(rd_data), 32'h1234);
    check("coll busy low", 32'(busy), 0);
    check("coll wr_done low", 32'(wr_done), 0);
    idle_inputs();
    tick();
    check("dropped req", 32'(rd_valid), 0);

    // Out-of-range write must leave the array alone.
    wr_req = 1'b1; wr_addr = 4'd13; wr_data = 16'hFFFF; wr_be = 2'b11;
    tick();
    idle_inputs();
    check("oor wr_done", 32'(wr_done), 1);
    check("oor wr err", 32'(err_addr), 1);
    tick();
    check("oor err clears", 32'(err_addr), 0);

    // Full sweep every cycle: 16 valid pulses, 12..15 flagged and zero.
    for (int a = 0; a < 16; a++) begin
      rd_req = 1'b1; rd_addr = ADDR_W'(a);
      tick();
      check($sformatf("sweep valid %0d", a), 32'(rd_valid), 1);
      check($sformatf("sweep busy %0d", a), 32'(busy), 0);
      check($sformatf("sweep data %0d", a), 32'(rd_data), 32'(exp_mem[a]));
      check($sformatf("sweep err %0d", a), 32'(err_addr), (a >= DEPTH) ? 1 : 0);
    end
    idle_inputs();
    tick();

    // Reset while a read is pending discards it; the write still lands.
    wr_req = 1'b1; wr_addr = 4'd9; wr_data = 16'h5A5A; wr_be = 2'b11;
    rd_req = 1'b1; rd_addr = 4'd9;
    tick();
    check("pend busy", 32'(busy), 1);
    idle_inputs();
    rst_n = 1'b0;
    tick();
    check("midrst rd_valid", 32'(rd_valid), 0);
    check("midrst busy", 32'(busy), 0);
    check("midrst wr_done", 32'(wr_done), 0);
    check("midrst err", 32'(err_addr), 0);
    check("midrst rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;
    tick();
    check("postrst no valid", 32'(rd_valid), 0);
    rd_req = 1'b1; rd_addr = 4'd9;
    tick();
    idle_inputs();
    check("postrst valid", 32'(rd_valid), 1);
    check("postrst mem kept", 32'(rd_data), 32'h5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_ram.md
# data_ram

Parametrised single-port data memory for the CPU datapath with request/response handshakes, byte-enabled writes, and defined read/write collision ordering. It replaces the fixed 16×16 data memory and sits between the execute stage and the load/store path, which issues one-cycle requests and waits for `rd_valid` / `wr_done`. Array contents survive reset; only the control state is reset.

## Interface
Parameters:
- `DATA_W`, 16: word width in bits; must be a multiple of 8.
- `ADDR_W`, 4: address width in bits.
- `DEPTH`, 16: number of words; `DEPTH <= 2**ADDR_W`.
- `INIT_WORDS`, 4: power-up content is word i = i+1 for i < `INIT_WORDS`, and 0 otherwise.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rd_req`  in  1  read request; sampled only when `busy`=0.
- `rd_addr`  in  `ADDR_W`  read word address.
- `wr_req`  in  1  write request; sampled only when `busy`=0.
- `wr_addr`  in  `ADDR_W`  write word address.
- `wr_data`  in  `DATA_W`  write data.
- `wr_be`  in  `DATA_W/8`  byte enables; bit k enables byte k, bits [8k+7:8k].
- `rd_data`  out  `DATA_W`  read result; holds its value between reads.
- `rd_valid`  out  1  one-cycle pulse: `rd_data` is updated.
- `wr_done`  out  1  one-cycle pulse: write completed.
- `busy`  out  1  high while a deferred read is pending; requests are ignored.
- `err_addr`  out  1  pulse alongside `rd_valid` or `wr_done` when that access address is >= `DEPTH`.

## Operation
- FSM states: IDLE and RD_PEND.
- **IDLE, read only** (`rd_req`=1, `wr_req`=0): read the array. Stay in IDLE.
- **IDLE, write only** (`wr_req`=1, `rd_req`=0): write the enabled bytes. Stay in IDLE.
- **IDLE, both requests in the same cycle:**
  - Perform the write this cycle.
  - Latch `rd_addr` and go to RD_PEND.
  - In RD_PEND, perform the read. The read returns post-write data, including same-address collisions. Return to IDLE.
- `busy` = 1 exactly while in RD_PEND. Requests presented during RD_PEND are dropped; the requester must retry.
- Back-to-back single requests with `busy`=0 are accepted every cycle, giving full throughput.
- **Out-of-range address** (>= `DEPTH`):
  - Write: the array is untouched; `wr_done` and `err_addr` pulse.
  - Read: `rd_data` is set to 0; `rd_valid` and `err_addr` pulse.
- `wr_be` = 0: nothing is written, but `wr_done` still pulses.
- **Reset** (`rst_n`=0 at an edge):
  - FSM goes to IDLE; any pending read is discarded, even mid-RD_PEND.
  - `rd_data`=0, `rd_valid`=0, `wr_done`=0, `busy`=0, `err_addr`=0.
  - The array is unchanged. Requests in the reset cycle are ignored.

## Timing
- Read accepted at edge N: `rd_data` and `rd_valid` appear after edge N, visible during cycle N+1. `rd_valid` is high for exactly one cycle.
- Write accepted at edge N: the array is updated at edge N; `wr_done` is high during cycle N+1.
- Simultaneous requests at edge N:
  - `wr_done` and `busy` are high in cycle N+1.
  - The read executes at edge N+1; `rd_valid` is high in cycle N+2; `busy` is low in cycle N+2.
- Read-during-write to the same address in IDLE cannot occur, because simultaneous requests are always serialised through RD_PEND.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `data_mem_pkg`: state enum `dm_state_t` {IDLE, RD_PEND}, plus a helper function computing `DATA_W/8`.
- Sub-module `ram_core`: single-port synchronous array with per-byte write enables and parametrised init contents. It holds no control logic.
- Top level `data_ram`: FSM, request arbitration, range check, and output registers.
- Elaborate-time checks: error if `DATA_W % 8 != 0` or `DEPTH > 2**ADDR_W`.

## Test plan
- Power-up reads of addresses 0..5 after reset → 1, 2, 3, 4, 0, 0; each `rd_valid` one cycle after its request, and no `err_addr`.
- Write 0xABCD to address 7 with `wr_be`=2'b01, over 0 → `wr_done` next cycle; a later read returns 0x00CD.
- Simultaneous `wr_req` (addr 2, 0x1234, `wr_be`=2'b11) and `rd_req` (addr 2):
  - cycle N+1: `wr_done`=1, `busy`=1.
  - cycle N+2: `rd_valid`=1, `rd_data`=0x1234.
  - A `rd_req` held in N+1 is dropped and produces no pulse.
- With `DEPTH`=12, write to address 13 → `wr_done` and `err_addr` pulse together; all twelve words are unchanged. A read of address 14 → `rd_data`=0 with `rd_valid` and `err_addr` pulsing together.
- Reset asserted during RD_PEND → no `rd_valid` afterwards; all outputs 0; the memory still holds the earlier write.
- Reads issued every cycle to addresses 0..15 → 16 consecutive `rd_valid` pulses with `busy` never asserted.
